mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port memory with a
// fixed read latency. One transaction is in flight at a time. Ties between
// fetch and data are broken round-robin.
//
// Handshake: a requester raises req with its address (and, for data, we/wdata)
// and holds them until its ack. gnt pulses for one cycle when the request is
// taken; after that, the requester's address and data inputs are ignored
// until ack. ack pulses for one cycle, and for reads the rdata output is
// updated in that same cycle. A req that is still high in the cycle after ack
// counts as a new request.
module mem_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 1   // memory read latency, 1..7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last WAIT count before moving to DONE (unused when LAT == 1).
  localparam logic [2:0] WAIT_LAST = 3'(LAT - 2);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          last_d_q, last_d_d;   // 1: data was served most recently
  logic          owner_q, owner_d;     // 1: current transaction belongs to data
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          f_gnt_q, f_gnt_d;
  logic          d_gnt_q, d_gnt_d;
  logic          f_ack_q, f_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pick_data;

  // Data wins when it is alone, or on a tie when fetch was served last.
  assign pick_data = d_req && (!f_req || !last_d_q);

  // Next-state and datapath decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          state_d  = S_ACCESS;
          owner_d  = pick_data;
          last_d_d = pick_data;
          addr_d   = pick_data ? d_addr : f_addr;
          we_d     = pick_data && d_we;
          wdata_d  = pick_data ? d_wdata : '0;
          f_gnt_d  = !pick_data;
          d_gnt_d  = pick_data;
        end
      end
      S_ACCESS: begin
        cnt_d   = '0;
        state_d = (LAT == 1) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        // Read data is valid during DONE; it is captured with the ack.
        state_d = S_IDLE;
        cnt_d   = '0;
        if (owner_q) begin
          d_ack_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          f_ack_d   = 1'b1;
          f_rdata_d = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_gnt_q   <= f_gnt_d;
      d_gnt_q   <= d_gnt_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
  assign f_gnt     = f_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LAT=1 instance checked cycle by cycle against a
// transaction-level reference model, plus a LAT=3 instance for latency and
// mid-transaction reset checks.
module tb_mem_arbiter;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT (LAT=1) ----------------
  logic        f_req, f_gnt, f_ack, d_req, d_we, d_gnt, d_ack;
  logic [15:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  mem_arbiter #(.AW(16), .DW(16), .LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT (LAT=3) ----------------
  logic        f_req3, f_gnt3, f_ack3, d_req3, d_we3, d_gnt3, d_ack3;
  logic [15:0] f_addr3, f_rdata3, d_addr3, d_wdata3, d_rdata3;
  logic        mem_en3, mem_we3, busy3;
  logic [15:0] mem_addr3, mem_wdata3, mem_rdata3;
  logic [1:0]  dbg_state3;

  mem_arbiter #(.AW(16), .DW(16), .LAT(LAT3)) u_dut3 (
    .clk(clk), .reset(reset),
    .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_ack(f_ack3), .f_rdata(f_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .dbg_state(dbg_state3)
  );

  // ---------------- memory device ----------------
  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a == 16'h0004) return 16'hB123;
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  logic [15:0] tb_mem [0:65535];
  bit          tb_wr  [0:65535];
  logic [15:0] p3 [0:2];

  // Non-read cycles return noise so a mistimed capture is visible.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      tb_wr[mem_addr]  <= 1'b1;
    end
    mem_rdata <= (mem_en && !mem_we)
                 ? (tb_wr[mem_addr] ? tb_mem[mem_addr] : init_word(mem_addr))
                 : 16'($urandom);
  end

  always @(posedge clk) begin
    p3[0] <= (mem_en3 && !mem_we3)
             ? (tb_wr[mem_addr3] ? tb_mem[mem_addr3] : init_word(mem_addr3))
             : 16'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  // ---------------- scoreboard / counters ----------------
  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t: no response within cycle budget", name, $time);
  endfunction

  // ---------------- reference model ----------------
  // One transaction at a time; the arbiter is free again LAT+2 edges after a
  // grant. Ties go to whoever was not served last (data after reset).
  typedef struct {
    int          gnt_edge;
    bit          who;      // 1: data
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        txn_q[$];
  logic [15:0] f_exp_q[$];
  logic [15:0] d_exp_q[$];
  bit          gnt_log[$];
  logic [15:0] mdl_mem [int];
  int          edge_cnt;
  int          free_edge;
  bit          last_who;
  logic [15:0] d_rd_mdl;

  function automatic logic [15:0] mdl_read(input logic [15:0] a);
    if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
    return init_word(a);
  endfunction

  initial begin : model
    txn_t t;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        edge_cnt  = 0;
        free_edge = 1;
        last_who  = 1'b1;
        d_rd_mdl  = '0;
        txn_q.delete();
        f_exp_q.delete();
        d_exp_q.delete();
      end else begin
        edge_cnt++;
        if (edge_cnt >= free_edge && (f_req || d_req)) begin
          t.who      = (f_req && d_req) ? !last_who : d_req;
          last_who   = t.who;
          t.gnt_edge = edge_cnt;
          t.addr     = t.who ? d_addr : f_addr;
          t.we       = t.who && d_we;
          t.wdata    = t.who ? d_wdata : 16'h0000;
          if (t.we) begin
            mdl_mem[int'(t.addr)] = t.wdata;
            d_exp_q.push_back(d_rd_mdl);
          end else if (t.who) begin
            d_rd_mdl = mdl_read(t.addr);
            d_exp_q.push_back(d_rd_mdl);
          end else begin
            f_exp_q.push_back(mdl_read(t.addr));
          end
          txn_q.push_back(t);
          free_edge = edge_cnt + LAT + 2;
        end
      end
    end
  end

  // ---------------- monitor (LAT=1 instance) ----------------
  initial begin : monitor
    txn_t t;
    bit   have, e_g, e_a, e_b;
    int   n;
    forever begin
      @(negedge clk);
      if (reset) begin
        have = (txn_q.size() > 0);
        n    = edge_cnt;
        e_g  = 1'b0;
        e_a  = 1'b0;
        e_b  = 1'b0;
        if (have) begin
          t   = txn_q[0];
          e_g = (t.gnt_edge == n);
          e_a = (n == t.gnt_edge + LAT + 1);
          e_b = (n >= t.gnt_edge) && (n <= t.gnt_edge + LAT);
        end
        chk("f_gnt",  32'(f_gnt),  32'(e_g && !t.who));
        chk("d_gnt",  32'(d_gnt),  32'(e_g && t.who));
        chk("f_ack",  32'(f_ack),  32'(e_a && !t.who));
        chk("d_ack",  32'(d_ack),  32'(e_a && t.who));
        chk("mem_en", 32'(mem_en), 32'(e_g));
        chk("mem_we", 32'(mem_we), 32'(e_g && t.we));
        chk("busy",   32'(busy),   32'(e_b));
        if (f_gnt) gnt_log.push_back(1'b0);
        if (d_gnt) gnt_log.push_back(1'b1);
        if (e_g) begin
          chk("mem_addr", 32'(mem_addr), 32'(t.addr));
          if (t.we) chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
        end
        if (e_a) begin
          if (t.who) begin
            if (d_exp_q.size() > 0) chk("d_rdata", 32'(d_rdata), 32'(d_exp_q.pop_front()));
            else timeout_fail("d_exp_empty");
          end else begin
            if (f_exp_q.size() > 0) chk("f_rdata", 32'(f_rdata), 32'(f_exp_q.pop_front()));
            else timeout_fail("f_exp_empty");
          end
          void'(txn_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Each returns at the negedge of the ack cycle with req still high when keep=1.
  task automatic f_txn(input logic [15:0] a, input bit keep);
    int n;
    f_req  = 1'b1;
    f_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_gnt && n < 64);
    if (!f_gnt) begin timeout_fail("f_gnt_wait"); f_req = 1'b0; return; end
    f_addr = 16'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!f_ack && n < 64);
    if (!f_ack) timeout_fail("f_ack_wait");
    if (!keep) f_req = 1'b0;
  endtask

  task automatic d_txn(input logic [15:0] a, input bit we, input logic [15:0] wd, input bit keep);
    int n;
    d_req   = 1'b1;
    d_addr  = a;
    d_we    = we;
    d_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_gnt && n < 64);
    if (!d_gnt) begin timeout_fail("d_gnt_wait"); d_req = 1'b0; return; end
    d_addr  = 16'($urandom);
    d_wdata = 16'($urandom);
    d_we    = 1'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 64);
    if (!d_ack) timeout_fail("d_ack_wait");
    if (!keep) d_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [15:0] exp3;
    reset = 1'b0;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    f_req3 = 1'b0; f_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = '0; d_wdata3 = '0;
    repeat (3) @(negedge clk);

    // Outputs while reset is held.
    chk("rst f_gnt",    32'(f_gnt),    32'(0));
    chk("rst d_ack",    32'(d_ack),    32'(0));
    chk("rst mem_en",   32'(mem_en),   32'(0));
    chk("rst busy",     32'(busy),     32'(0));
    chk("rst mem_addr", 32'(mem_addr), 32'(0));
    chk("rst f_rdata",  32'(f_rdata),  32'(0));
    chk("rst d_rdata",  32'(d_rdata),  32'(0));
    chk("rst busy3",    32'(busy3),    32'(0));

    // Lone fetch of word 4 straight out of reset.
    reset = 1'b1;
    f_txn(16'h0004, 1'b0);
    chk("lone fetch data", 32'(f_rdata), 32'(16'hB123));

    // Tie right after reset: fetch first.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    gnt_log.delete();
    fork
      f_txn(16'h0100, 1'b0);
      d_txn(16'h0200, 1'b0, 16'h0000, 1'b0);
    join
    chk("tie count", 32'(gnt_log.size()), 32'(2));
    if (gnt_log.size() == 2) chk("tie first", 32'(gnt_log[0]), 32'(0));

    // Write to the top address, then read it back.
    @(negedge clk);
    d_txn(16'hFFFF, 1'b1, 16'h00A5, 1'b0);
    d_txn(16'hFFFF, 1'b0, 16'h0000, 1'b0);
    chk("readback FFFF", 32'(d_rdata), 32'(16'h00A5));

    // Both requests held for 8 transactions.
    gnt_log.delete();
    fork
      for (int i = 0; i < 4; i++) f_txn(16'(16'h0300 + i), (i < 3));
      for (int i = 0; i < 4; i++) d_txn(16'(16'h0400 + i), 1'(i[0]), 16'(16'h7700 + i), (i < 3));
    join
    chk("alt count", 32'(gnt_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("alt order", 32'(gnt_log[i]), 32'(i % 2));

    // Random traffic on both ports.
    fork
      for (int i = 0; i < 40; i++) begin
        bit keep;
        keep = (i < 39) && ($urandom_range(0, 1) == 1);
        f_txn((($urandom_range(0, 1) == 1) ? {12'hFFF, 4'($urandom)} : 16'($urandom)), keep);
        if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      for (int i = 0; i < 40; i++) begin
        bit keep;
        keep = (i < 39) && ($urandom_range(0, 1) == 1);
        d_txn((($urandom_range(0, 1) == 1) ? {12'hFFF, 4'($urandom)} : 16'($urandom)),
              ($urandom_range(0, 1) == 1), 16'($urandom), keep);
        if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    join
    repeat (3) @(negedge clk);

    // LAT=3 fetch: grant on edge 1, ack on edge 5, address held while waiting.
    f_req3  = 1'b1;
    f_addr3 = 16'h0040;
    exp3    = mdl_read(16'h0040);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("l3 f_gnt",  32'(f_gnt3),  32'(k == 1));
      chk("l3 mem_en", 32'(mem_en3), 32'(k == 1));
      chk("l3 f_ack",  32'(f_ack3),  32'(k == 5));
      if (k == 1) f_addr3 = 16'hBEEF;
      if (k == 1 || k == 3) chk("l3 mem_addr", 32'(mem_addr3), 32'(16'h0040));
      if (f_ack3) begin
        chk("l3 f_rdata", 32'(f_rdata3), 32'(exp3));
        f_req3 = 1'b0;
      end
    end

    // Reset during WAIT: everything clears at once, no ack afterwards.
    f_req3  = 1'b1;
    f_addr3 = 16'h0044;
    repeat (2) @(negedge clk);
    chk("l3 busy in wait", 32'(busy3), 32'(1));
    #2 reset = 1'b0;
    #1;
    chk("async f_gnt3",    32'(f_gnt3),    32'(0));
    chk("async f_ack3",    32'(f_ack3),    32'(0));
    chk("async mem_en3",   32'(mem_en3),   32'(0));
    chk("async busy3",     32'(busy3),     32'(0));
    chk("async mem_addr3", 32'(mem_addr3), 32'(0));
    chk("async f_rdata3",  32'(f_rdata3),  32'(0));
    chk("async mem_addr",  32'(mem_addr),  32'(0));
    f_req3 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no ack after reset", 32'(f_ack3), 32'(0));
    end

    chk("pending txns", 32'(txn_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
